// File: rtl/nes_joypad_port_if.sv
// 2A03 CPU bus as seen by the $4016/$4017 joypad responder.
// master = CPU side, slave = joypad port.
interface nes_joypad_port_if;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data_in;
    logic        cpu_rnw;
    logic        cpu_m2;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_oe;

    modport master (
        output cpu_address, cpu_data_in, cpu_rnw, cpu_m2,
        input  cpu_data_out, cpu_data_oe
    );

    modport slave (
        input  cpu_address, cpu_data_in, cpu_rnw, cpu_m2,
        output cpu_data_out, cpu_data_oe
    );
endinterface

// File: rtl/nes_joypad_port.sv
// NES controller ports at $4016/$4017: strobe latch, 4021-style serial shift-out per read.
// Optional button debounce filter enabled by defining NES_JOYPAD_DEBOUNCE_EN.
module nes_joypad_port #(
    parameter logic [15:0] ADDR_P1         = 16'h4016,
    parameter logic [15:0] ADDR_P2         = 16'h4017,
    parameter logic [2:0]  OPEN_BUS_HI     = 3'b010,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned DB_W            = 16
) (
    input  logic                clk,
    input  logic                rstn,
    nes_joypad_port_if.slave    bus,
    input  logic [7:0]          p1_buttons,
    input  logic [7:0]          p2_buttons,
    output logic                strobe
);

    if (DB_W < $clog2(DEBOUNCE_CYCLES + 1)) begin : g_db_w_too_small
        $error("DB_W too narrow to hold DEBOUNCE_CYCLES");
    end

    logic [7:0]  p1_meta, p1_sync;
    logic [7:0]  p2_meta, p2_sync;
    logic [15:0] btn_raw;
    logic [15:0] btn_filt;
    logic [7:0]  btn_p1, btn_p2;
    logic        m2_q;
    logic        m2_fall;
    logic        sel_p1, sel_p2;
    logic [7:0]  sr1, sr2;
    logic [6:0]  unused_data_hi;

    assign unused_data_hi = bus.cpu_data_in[7:1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p1_meta <= '0;
            p1_sync <= '0;
            p2_meta <= '0;
            p2_sync <= '0;
            m2_q    <= 1'b0;
        end else begin
            p1_meta <= p1_buttons;
            p1_sync <= p1_meta;
            p2_meta <= p2_buttons;
            p2_sync <= p2_meta;
            m2_q    <= bus.cpu_m2;
        end
    end

    assign btn_raw = {p2_sync, p1_sync};

`ifdef NES_JOYPAD_DEBOUNCE_EN
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt [16];

    // Counter runs only while raw disagrees with filtered; flip on the Nth consecutive mismatch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            btn_filt <= '0;
            for (int unsigned i = 0; i < 16; i++) db_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (btn_raw[i] == btn_filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    btn_filt[i] <= btn_raw[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        btn_filt = btn_raw;
    end
`endif

    assign btn_p1  = btn_filt[7:0];
    assign btn_p2  = btn_filt[15:8];
    assign m2_fall = m2_q & ~bus.cpu_m2;
    assign sel_p1  = (bus.cpu_address == ADDR_P1);
    assign sel_p2  = (bus.cpu_address == ADDR_P2);

    // Reload looks at the registered strobe, so a same-cycle strobe write sees the old value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            strobe <= 1'b0;
            sr1    <= '0;
            sr2    <= '0;
        end else begin
            if (m2_fall && !bus.cpu_rnw && sel_p1)
                strobe <= bus.cpu_data_in[0];

            if (strobe)
                sr1 <= btn_p1;
            else if (m2_fall && bus.cpu_rnw && sel_p1)
                sr1 <= {1'b1, sr1[7:1]};

            if (strobe)
                sr2 <= btn_p2;
            else if (m2_fall && bus.cpu_rnw && sel_p2)
                sr2 <= {1'b1, sr2[7:1]};
        end
    end

    always_comb begin
        bus.cpu_data_oe  = rstn & bus.cpu_m2 & bus.cpu_rnw & (sel_p1 | sel_p2);
        bus.cpu_data_out = 8'h00;
        if (bus.cpu_data_oe)
            bus.cpu_data_out = {OPEN_BUS_HI, 4'b0000, (sel_p1 ? sr1[0] : sr2[0])};
    end

endmodule

// File: tb/tb_nes_joypad_port.sv
// Self-checking bench for nes_joypad_port: directed tables, corner sequences, random vs. model.
module tb_nes_joypad_port;

`ifdef NES_JOYPAD_DEBOUNCE_EN
    localparam int unsigned DBC    = 8;
    localparam int          SETTLE = 16;
`else
    localparam int unsigned DBC    = 50000;
    localparam int          SETTLE = 4;
`endif

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } vec_t;

    logic       clk;
    logic       rstn;
    logic [7:0] p1_buttons;
    logic [7:0] p2_buttons;
    logic       strobe;
    int         total;
    int         bad;

    nes_joypad_port_if bus ();

    nes_joypad_port #(
        .DEBOUNCE_CYCLES(DBC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .p1_buttons (p1_buttons),
        .p2_buttons (p2_buttons),
        .strobe     (strobe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%02h required=%02h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cpu_address = a;
        bus.cpu_data_in = d;
        bus.cpu_rnw     = 1'b0;
        bus.cpu_m2      = 1'b1;
        idle(2);
        bus.cpu_m2 = 1'b0;
        idle(2);
        bus.cpu_rnw = 1'b1;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic oe);
        @(negedge clk);
        bus.cpu_address = a;
        bus.cpu_rnw     = 1'b1;
        bus.cpu_m2      = 1'b1;
        idle(2);
        d  = bus.cpu_data_out;
        oe = bus.cpu_data_oe;
        bus.cpu_m2 = 1'b0;
        idle(2);
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       oe;
        bus_read(a, d, oe);
        check8(name, d, exp);
        check8({name, "_oe"}, {7'b0, oe}, 8'h01);
    endtask

    task automatic strobe_pulse();
        bus_write(16'h4016, 8'h01);
        bus_write(16'h4016, 8'h00);
    endtask

    // Reference: bit k of the latched snapshot is the k-th read after the strobe falls; 1 afterwards.
    function automatic logic exp_bit(input logic [7:0] snap, input int n);
        return (n < 8) ? snap[n] : 1'b1;
    endfunction

    vec_t       t2 [12];
    logic [7:0] t2_bits;
    logic [7:0] rd;
    logic       rd_oe;
    logic [7:0] lat1, lat2;
    int         cnt1, cnt2;
    logic       mstrobe;

    initial begin
        total = 0;
        bad   = 0;

        t2_bits = 8'b0000_1001;
        t2[0] = '{1'b1, 16'h4016, 8'h01};
        t2[1] = '{1'b1, 16'h4016, 8'h00};
        for (int i = 0; i < 10; i++)
            t2[i + 2] = '{1'b0, 16'h4016, 8'h40 | {7'b0, exp_bit(t2_bits, i)}};

        // T1 reset with all buttons pressed
        rstn            = 1'b0;
        p1_buttons      = 8'hFF;
        p2_buttons      = 8'hFF;
        bus.cpu_address = 16'h0000;
        bus.cpu_data_in = 8'h00;
        bus.cpu_rnw     = 1'b1;
        bus.cpu_m2      = 1'b0;
        idle(4);
        check8("t1_strobe", {7'b0, strobe}, 8'h00);
        check8("t1_oe", {7'b0, bus.cpu_data_oe}, 8'h00);
        check8("t1_dout", bus.cpu_data_out, 8'h00);
        rstn = 1'b1;
        idle(SETTLE);
        read_check("t1_first_read", 16'h4016, 8'h40);

        // T2 standard poll from table
        p1_buttons = t2_bits;
        p2_buttons = 8'h00;
        idle(SETTLE);
        for (int i = 0; i < 12; i++) begin
            if (t2[i].wr)
                bus_write(t2[i].addr, t2[i].data);
            else
                read_check($sformatf("t2_read%0d", i - 2), t2[i].addr, t2[i].data);
        end
        check8("t2_idle_dout", bus.cpu_data_out, 8'h00);

        // T3 strobe held returns live A
        p1_buttons = 8'h01;
        idle(SETTLE);
        bus_write(16'h4016, 8'h01);
        for (int i = 0; i < 3; i++) read_check($sformatf("t3_held%0d", i), 16'h4016, 8'h41);
        check8("t3_strobe", {7'b0, strobe}, 8'h01);
        p1_buttons = 8'h00;
        idle(SETTLE);
        read_check("t3_live_drop", 16'h4016, 8'h40);
        bus_write(16'h4016, 8'h00);

        // T4 port independence
        p1_buttons = 8'h01;
        p2_buttons = 8'h80;
        idle(SETTLE);
        strobe_pulse();
        for (int i = 0; i < 7; i++) read_check($sformatf("t4_p2_read%0d", i), 16'h4017, 8'h40);
        read_check("t4_p2_read7", 16'h4017, 8'h41);
        read_check("t4_p1_unshifted", 16'h4016, 8'h41);

        // T5 ignored write, mid-sequence reset, button toggles while frozen
        bus_write(16'h4017, 8'h01);
        check8("t5_4017_write", {7'b0, strobe}, 8'h00);
        bus_read(16'h4018, rd, rd_oe);
        check8("t5_other_oe", {7'b0, rd_oe}, 8'h00);
        check8("t5_other_dout", rd, 8'h00);
        p1_buttons = 8'h0F;
        idle(SETTLE);
        strobe_pulse();
        for (int i = 0; i < 3; i++) read_check($sformatf("t5_pre_reset%0d", i), 16'h4016, 8'h41);
        @(negedge clk);
        rstn = 1'b0;
        idle(3);
        check8("t5_reset_strobe", {7'b0, strobe}, 8'h00);
        rstn = 1'b1;
        idle(SETTLE);
        read_check("t5_after_reset", 16'h4016, 8'h40);
        p1_buttons = 8'h05;
        idle(SETTLE);
        strobe_pulse();
        for (int i = 0; i < 9; i++) begin
            p1_buttons = 8'($urandom);
            idle(SETTLE);
            read_check($sformatf("t5_toggle%0d", i), 16'h4016, 8'h40 | {7'b0, exp_bit(8'h05, i)});
        end

`ifdef NES_JOYPAD_DEBOUNCE_EN
        // T6 glitch rejected, long press accepted
        p1_buttons = 8'h00;
        idle(SETTLE);
        bus_write(16'h4016, 8'h01);
        p1_buttons = 8'h01;
        idle(5);
        p1_buttons = 8'h00;
        idle(20);
        bus_write(16'h4016, 8'h00);
        read_check("t6_short_pulse", 16'h4016, 8'h40);
        bus_write(16'h4016, 8'h01);
        p1_buttons = 8'h01;
        idle(12);
        bus_write(16'h4016, 8'h00);
        p1_buttons = 8'h00;
        read_check("t6_long_hold", 16'h4016, 8'h41);
        idle(SETTLE);
`endif

        // Random bus traffic against the snapshot model
        p1_buttons = 8'($urandom);
        p2_buttons = 8'($urandom);
        idle(SETTLE);
        strobe_pulse();
        lat1    = p1_buttons;
        lat2    = p2_buttons;
        cnt1    = 0;
        cnt2    = 0;
        mstrobe = 1'b0;
        for (int op = 0; op < 300; op++) begin
            int unsigned r;
            logic [7:0]  d;
            logic        b;
            r = $urandom_range(0, 11);
            if (r == 0) begin
                p1_buttons = 8'($urandom);
                p2_buttons = 8'($urandom);
                idle(SETTLE);
            end else if (r <= 2) begin
                d = 8'($urandom);
                bus_write(16'h4016, d);
                if (mstrobe && !d[0]) begin
                    lat1 = p1_buttons;
                    lat2 = p2_buttons;
                    cnt1 = 0;
                    cnt2 = 0;
                end
                mstrobe = d[0];
            end else if (r == 3) begin
                case ($urandom_range(0, 2))
                    0:       bus_write(16'h4017, 8'($urandom));
                    1:       bus_write(16'h4015, 8'($urandom));
                    default: bus_write(16'h0016, 8'($urandom));
                endcase
                check8($sformatf("rnd_strobe_op%0d", op), {7'b0, strobe}, {7'b0, mstrobe});
            end else if (r == 4) begin
                bus_read(16'h4416, rd, rd_oe);
                check8($sformatf("rnd_unmapped_op%0d", op), {rd_oe, rd[6:0]}, 8'h00);
            end else if (r <= 7) begin
                b = mstrobe ? p1_buttons[0] : exp_bit(lat1, cnt1);
                if (!mstrobe) cnt1++;
                read_check($sformatf("rnd_p1_op%0d", op), 16'h4016, 8'h40 | {7'b0, b});
            end else begin
                b = mstrobe ? p2_buttons[0] : exp_bit(lat2, cnt2);
                if (!mstrobe) cnt2++;
                read_check($sformatf("rnd_p2_op%0d", op), 16'h4017, 8'h40 | {7'b0, b});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
